// File: rtl/controller_serial_reader_if.sv
// Controller-side and CPU-side signals of the serial gamepad reader.
// The reader owns the master modport; the system (pads and CPU registers) uses slave.
interface controller_serial_reader_if #(
  parameter int NUM_CONTROLLERS = 2
);
  logic                         controller_start_fetch;
  logic                         controller_latch;
  logic                         controller_clk_out_enable;
  logic [NUM_CONTROLLERS-1:0]   controller_data_in_B;
  logic [8*NUM_CONTROLLERS-1:0] buttons_out;
  logic [8*NUM_CONTROLLERS-1:0] pressed_out;
  logic [8*NUM_CONTROLLERS-1:0] released_out;
  logic                         frame_valid;
  logic                         busy;

  modport master (
    input  controller_start_fetch,
    input  controller_data_in_B,
    output controller_latch,
    output controller_clk_out_enable,
    output buttons_out,
    output pressed_out,
    output released_out,
    output frame_valid,
    output busy
  );

  modport slave (
    output controller_start_fetch,
    output controller_data_in_B,
    input  controller_latch,
    input  controller_clk_out_enable,
    input  buttons_out,
    input  pressed_out,
    input  released_out,
    input  frame_valid,
    input  busy
  );
endinterface

// File: rtl/controller_serial_reader.sv
// Once-per-frame NES-style serial pad reader: latch, shift 8 bits per pad,
// then commit all button bytes and press/release edge flags on one edge.
module controller_serial_reader #(
  parameter int NUM_CONTROLLERS = 2,
  parameter int LATCH_CYCLES    = 2
) (
  input  logic                        controller_clk_in,
  input  logic                        rst_B,
  controller_serial_reader_if.master  bus
);
  localparam int          BW         = 8 * NUM_CONTROLLERS;
  localparam logic [3:0]  LATCH_LAST = 4'(LATCH_CYCLES - 1);
  localparam logic [3:0]  SHIFT_LAST = 4'd7;

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            start_prev;
  logic            start_evt;
  logic            shift_en;
  logic            commit;

  logic [BW-1:0]   shift_p0;
  logic [BW-1:0]   buttons_p1;
  logic [BW-1:0]   pressed_p1;
  logic [BW-1:0]   released_p1;

  assign start_evt = bus.controller_start_fetch & ~start_prev;

  always_ff @(posedge controller_clk_in) begin
    if (!rst_B) begin
      state      <= IDLE;
      cnt        <= '0;
      start_prev <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      start_prev <= bus.controller_start_fetch;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start_evt) begin
          state_nxt = LATCH;
          cnt_nxt   = '0;
        end
      end
      LATCH: begin
        if (cnt == LATCH_LAST) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + 4'd1;
        end
      end
      SHIFT: begin
        if (cnt == SHIFT_LAST) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt + 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The last shift cycle samples without clocking, so the pads see exactly 7 pulses.
  always_comb begin
    bus.controller_latch          = 1'b0;
    bus.controller_clk_out_enable = 1'b0;
    bus.frame_valid               = 1'b0;
    bus.busy                      = (state != IDLE);
    shift_en                      = 1'b0;
    commit                        = 1'b0;
    case (state)
      LATCH: bus.controller_latch = 1'b1;
      SHIFT: begin
        shift_en                      = 1'b1;
        bus.controller_clk_out_enable = (cnt != SHIFT_LAST);
      end
      DONE: begin
        bus.frame_valid = 1'b1;
        commit          = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage p0: serial capture, first bit (A) ends up in bit 7 of each byte
  always_ff @(posedge controller_clk_in) begin
    if (shift_en) begin
      for (int i = 0; i < NUM_CONTROLLERS; i++) begin
        shift_p0[8*i +: 8] <= {shift_p0[8*i +: 7], ~bus.controller_data_in_B[i]};
      end
    end
  end

  // Stage p1: atomic commit of all bytes and their edge flags
  always_ff @(posedge controller_clk_in) begin
    if (!rst_B) begin
      buttons_p1  <= '0;
      pressed_p1  <= '0;
      released_p1 <= '0;
    end else if (commit) begin
      buttons_p1  <= shift_p0;
      pressed_p1  <= shift_p0 & ~buttons_p1;
      released_p1 <= ~shift_p0 & buttons_p1;
    end
  end

  assign bus.buttons_out  = buttons_p1;
  assign bus.pressed_out  = pressed_p1;
  assign bus.released_out = released_p1;
endmodule

// File: tb/tb_controller_serial_reader.sv
// Scoreboard bench: two reader instances (2 pads/latch 2, 4 pads/latch 1) driven by
// behavioural pad models; expected frames are queued at start and checked by a monitor.
module tb_controller_serial_reader;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  typedef struct packed {
    int          start;
    logic [31:0] b;
    logic [31:0] p;
    logic [31:0] r;
  } sb_t;

  logic clk = 1'b0;
  logic rst_B;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  controller_serial_reader_if #(.NUM_CONTROLLERS(2)) ifa ();
  controller_serial_reader_if #(.NUM_CONTROLLERS(4)) ifb ();

  controller_serial_reader #(.NUM_CONTROLLERS(2), .LATCH_CYCLES(LAT_A)) dut_a (
    .controller_clk_in (clk),
    .rst_B             (rst_B),
    .bus               (ifa)
  );

  controller_serial_reader #(.NUM_CONTROLLERS(4), .LATCH_CYCLES(LAT_B)) dut_b (
    .controller_clk_in (clk),
    .rst_B             (rst_B),
    .bus               (ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad models: parallel load while latched, advance on each gated clock pulse.
  logic [31:0] pat [2] = '{32'h0, 32'h0};
  logic [15:0] sha = '0;
  logic [31:0] shb = '0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ifa.controller_latch) sha[8*i +: 8] <= pat[0][8*i +: 8];
      else if (ifa.controller_clk_out_enable) sha[8*i +: 8] <= {sha[8*i +: 7], 1'b0};
    end
    for (int i = 0; i < 4; i++) begin
      if (ifb.controller_latch) shb[8*i +: 8] <= pat[1][8*i +: 8];
      else if (ifb.controller_clk_out_enable) shb[8*i +: 8] <= {shb[8*i +: 7], 1'b0};
    end
  end

  assign ifa.controller_data_in_B = ~{sha[15], sha[7]};
  assign ifb.controller_data_in_B = ~{shb[31], shb[23], shb[15], shb[7]};

  logic        busy_w  [2];
  logic        latch_w [2];
  logic        en_w    [2];
  logic        fv_w    [2];
  logic [31:0] btn_w   [2];
  logic [31:0] prs_w   [2];
  logic [31:0] rel_w   [2];

  assign busy_w[0]  = ifa.busy;
  assign busy_w[1]  = ifb.busy;
  assign latch_w[0] = ifa.controller_latch;
  assign latch_w[1] = ifb.controller_latch;
  assign en_w[0]    = ifa.controller_clk_out_enable;
  assign en_w[1]    = ifb.controller_clk_out_enable;
  assign fv_w[0]    = ifa.frame_valid;
  assign fv_w[1]    = ifb.frame_valid;
  assign btn_w[0]   = {16'h0, ifa.buttons_out};
  assign btn_w[1]   = ifb.buttons_out;
  assign prs_w[0]   = {16'h0, ifa.pressed_out};
  assign prs_w[1]   = ifb.pressed_out;
  assign rel_w[0]   = {16'h0, ifa.released_out};
  assign rel_w[1]   = ifb.released_out;

  sb_t qa[$];
  sb_t qb[$];

  function automatic int q_size(input int d);
    return (d == 0) ? qa.size() : qb.size();
  endfunction

  function automatic sb_t q_front(input int d);
    if (d == 0) return qa[0];
    return qb[0];
  endfunction

  function automatic sb_t q_pop(input int d);
    if (d == 0) return qa.pop_front();
    return qb.pop_front();
  endfunction

  function automatic void q_push(input int d, input sb_t e);
    if (d == 0) qa.push_back(e);
    else qb.push_back(e);
  endfunction

  function automatic void q_clear(input int d);
    if (d == 0) qa.delete();
    else qb.delete();
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic logic [31:0] mask_of(input int d);
    return (d == 0) ? 32'h0000_ffff : 32'hffff_ffff;
  endfunction

  function automatic void chk(input string nm, input int d, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%08h expected 0x%08h", nm, d, cyc, act, exp);
    end
  endfunction

  // Monitor: control timing from the oldest pending read, outputs from the last frame.
  sb_t         pend_e [2];
  bit          pend   [2] = '{1'b0, 1'b0};
  logic [31:0] cur_b  [2] = '{32'h0, 32'h0};
  logic [31:0] cur_p  [2] = '{32'h0, 32'h0};
  logic [31:0] cur_r  [2] = '{32'h0, 32'h0};

  always @(negedge clk) begin : monitor
    sb_t f;
    int  s, dl, L;
    bit  act;
    for (int d = 0; d < 2; d++) begin
      L = lat_of(d);
      s = -1;
      if (q_size(d) > 0) begin
        f = q_front(d);
        s = f.start;
      end
      act = (s >= 0) && (cyc > s);
      dl  = cyc - s;
      if (pend[d]) begin
        cur_b[d] = pend_e[d].b;
        cur_p[d] = pend_e[d].p;
        cur_r[d] = pend_e[d].r;
        pend[d]  = 1'b0;
      end
      chk("busy",           d, 32'(busy_w[d]),  32'(act && dl <= L + 9));
      chk("latch",          d, 32'(latch_w[d]), 32'(act && dl <= L));
      chk("clk_out_enable", d, 32'(en_w[d]),    32'(act && dl > L && dl <= L + 7));
      chk("frame_valid",    d, 32'(fv_w[d]),    32'(act && dl == L + 9));
      chk("buttons_out",    d, btn_w[d], cur_b[d]);
      chk("pressed_out",    d, prs_w[d], cur_p[d]);
      chk("released_out",   d, rel_w[d], cur_r[d]);
      if (fv_w[d] && q_size(d) > 0) begin
        pend_e[d] = q_pop(d);
        pend[d]   = 1'b1;
      end
      if (!rst_B) begin
        q_clear(d);
        pend[d]  = 1'b0;
        cur_b[d] = '0;
        cur_p[d] = '0;
        cur_r[d] = '0;
      end
    end
  end

  // Stimulus side of the reference model.
  logic [31:0] prev   [2] = '{32'h0, 32'h0};
  int          last_s [2] = '{-1, -1};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) ifa.controller_start_fetch = v;
    else ifb.controller_start_fetch = v;
  endtask

  task automatic do_reset(input int n);
    rst_B     = 1'b0;
    prev[0]   = '0;
    prev[1]   = '0;
    last_s[0] = -1;
    last_s[1] = -1;
    tick(n);
    rst_B     = 1'b1;
  endtask

  // A read is accepted only when the reader is idle again: start + latch + 8 shifts + done.
  task automatic start_read(input int d, input logic [31:0] p, input int hold);
    sb_t         e;
    logic [31:0] m;
    m = mask_of(d);
    set_start(d, 1'b1);
    if (rst_B && (last_s[d] < 0 || cyc >= last_s[d] + lat_of(d) + 10)) begin
      pat[d]    = p & m;
      e.start   = cyc;
      e.b       = p & m;
      e.p       = e.b & ~prev[d];
      e.r       = ~e.b & prev[d] & m;
      prev[d]   = e.b;
      last_s[d] = cyc;
      q_push(d, e);
    end
    tick(hold);
    set_start(d, 1'b0);
    tick(1);
  endtask

  initial begin
    ifa.controller_start_fetch = 1'b0;
    ifb.controller_start_fetch = 1'b0;
    do_reset(3);
    tick(20);

    start_read(0, 32'h0000_0081, 1);
    tick(15);
    start_read(0, 32'h0000_0001, 1);
    tick(15);

    // second pulse four cycles into a read must be dropped
    start_read(0, 32'h0000_5aa5, 1);
    tick(2);
    start_read(0, 32'h0000_ffff, 1);
    tick(12);
    start_read(0, 32'h0000_c33c, 1);
    tick(15);

    // start on the DONE cycle is ignored, the next clean edge is taken
    start_read(0, 32'h0000_1234, 1);
    tick(9);
    start_read(0, 32'h0000_4321, 1);
    start_read(0, 32'h0000_0f0f, 1);
    tick(15);

    start_read(0, 32'h0000_f00f, 30);
    tick(15);

    // reset during SHIFT k=3 discards the read
    start_read(0, 32'h0000_00ff, 1);
    tick(4);
    do_reset(1);
    tick(3);
    start_read(0, 32'h0000_8142, 1);
    tick(15);

    start_read(1, 32'h7856_3412, 1);
    tick(15);
    start_read(1, 32'h0000_0000, 1);
    tick(15);

    for (int n = 0; n < 24; n++) begin
      automatic int          d = $urandom_range(0, 1);
      automatic logic [31:0] p = $urandom;
      start_read(d, p, $urandom_range(1, 3));
      tick($urandom_range(0, 14));
    end
    tick(20);

    chk("reads pending", 0, 32'(q_size(0)), 32'd0);
    chk("reads pending", 1, 32'(q_size(1)), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
